// File: rtl/wb_queue.sv
// wb_queue -- writeback buffer feeding the register file write port.
//
// Execute-stage results (dst, data) enter through a valid/ready handshake and
// are held in an in-order FIFO. The head entry drains to the register file
// during every write phase (regread low). The buffer also checks the three
// register-read sources against all pending entries. It flags RAW hazards and
// forwards the youngest matching value.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          producer handshake (in_ready = ~full)
//   in_dst, in_data            result destination register and value
//   regread                    1 = regfile read phase, 0 = write phase
//   regwrite                   write strobe (~empty & ~regread)
//   regwritedst, writedata     head entry, or 0 when empty
//   readregsrc1..3             read sources to compare
//   hazard[2:0]                bit i set when src(i+1) matches a pending entry
//   fwd_a/b/c                  youngest matching data per source, else 0
//   count, full, empty         registered occupancy status
module wb_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_dst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     regread,
  output logic                     regwrite,
  output logic [ADDR_W-1:0]        regwritedst,
  output logic [DATA_W-1:0]        writedata,
  input  logic [ADDR_W-1:0]        readregsrc1,
  input  logic [ADDR_W-1:0]        readregsrc2,
  input  logic [ADDR_W-1:0]        readregsrc3,
  output logic [2:0]               hazard,
  output logic [DATA_W-1:0]        fwd_a,
  output logic [DATA_W-1:0]        fwd_b,
  output logic [DATA_W-1:0]        fwd_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_dst  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [ADDR_W-1:0] w_src [3];
  logic [DATA_W-1:0] w_fwd [3];
  logic [2:0]        w_hazard;
  logic [PTR_W-1:0]  w_idx;

  // Full is taken from registered state, so a full queue refuses a push even
  // in a cycle where it also pops.
  assign w_push   = in_valid & ~r_full;
  assign w_pop    = ~r_empty & ~regread;

  assign in_ready    = ~r_full;
  assign full        = r_full;
  assign empty       = r_empty;
  assign count       = r_count;
  assign regwrite    = w_pop;
  assign regwritedst = r_empty ? {ADDR_W{1'b0}} : r_dst[r_head];
  assign writedata   = r_empty ? {DATA_W{1'b0}} : r_data[r_head];

  assign w_src[0] = readregsrc1;
  assign w_src[1] = readregsrc2;
  assign w_src[2] = readregsrc3;
  assign hazard   = w_hazard;
  assign fwd_a    = w_fwd[0];
  assign fwd_b    = w_fwd[1];
  assign fwd_c    = w_fwd[2];

  // Next occupancy, used so that full/empty are registered together with count.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1'b1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1'b1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy and valid-bit state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_vld   <= {DEPTH{1'b0}};
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == {CNT_W{1'b0}});
      // Push and pop never target the same slot: head equals tail only when
      // the queue is empty (no pop) or full (no push).
      if (w_push) begin
        r_tail        <= r_tail + PTR_W'(1'b1);
        r_vld[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head        <= r_head + PTR_W'(1'b1);
        r_vld[r_head] <= 1'b0;
      end
    end
  end

  // Entry storage, written at the tail on each accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_dst[i]  <= {ADDR_W{1'b0}};
        r_data[i] <= {DATA_W{1'b0}};
      end
    end else if (w_push) begin
      r_dst[r_tail]  <= in_dst;
      r_data[r_tail] <= in_data;
    end
  end

  // Hazard detection and forwarding. The scan runs from oldest (head) to
  // youngest, so the last match is the youngest one and its data wins. The
  // entry popping this cycle is still valid until the edge.
  always_comb begin
    w_hazard = 3'b000;
    w_idx    = {PTR_W{1'b0}};
    for (int s = 0; s < 3; s++) begin
      w_fwd[s] = {DATA_W{1'b0}};
    end
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_idx = r_head + PTR_W'(i);
        if (r_vld[w_idx] && (r_dst[w_idx] == w_src[s])) begin
          w_hazard[s] = 1'b1;
          w_fwd[s]    = r_data[w_idx];
        end else begin
          w_fwd[s]    = w_fwd[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_dst;
  logic [15:0] in_data;
  logic        regread;
  logic        regwrite;
  logic [3:0]  regwritedst;
  logic [15:0] writedata;
  logic [3:0]  readregsrc1;
  logic [3:0]  readregsrc2;
  logic [3:0]  readregsrc3;
  logic [2:0]  hazard;
  logic [15:0] fwd_a;
  logic [15:0] fwd_b;
  logic [15:0] fwd_c;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  wb_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dst      (in_dst),
    .in_data     (in_data),
    .regread     (regread),
    .regwrite    (regwrite),
    .regwritedst (regwritedst),
    .writedata   (writedata),
    .readregsrc1 (readregsrc1),
    .readregsrc2 (readregsrc2),
    .readregsrc3 (readregsrc3),
    .hazard      (hazard),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .fwd_c       (fwd_c),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dst      = 4'd0;
    in_data     = 16'h0000;
    regread     = 1'b1;
    readregsrc1 = 4'd15;
    readregsrc2 = 4'd15;
    readregsrc3 = 4'd15;
    tick();
    tick();
    #1;
    chk("rst_empty",    32'(empty),       32'd1);
    chk("rst_full",     32'(full),        32'd0);
    chk("rst_count",    32'(count),       32'd0);
    chk("rst_in_ready", 32'(in_ready),    32'd1);
    chk("rst_regwrite", 32'(regwrite),    32'd0);
    chk("rst_hazard",   32'(hazard),      32'd0);
    chk("rst_wdst",     32'(regwritedst), 32'd0);
    chk("rst_wdata",    32'(writedata),   32'd0);
    chk("rst_fwd_a",    32'(fwd_a),       32'd0);
    rst_n = 1'b1;
    tick();

    // Single push during read phase, then commit in write phase.
    in_valid = 1'b1; in_dst = 4'd3; in_data = 16'habcd;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t2_count",     32'(count),       32'd1);
    chk("t2_rw_read",   32'(regwrite),    32'd0);
    regread = 1'b0;
    #1;
    chk("t2_regwrite",  32'(regwrite),    32'd1);
    chk("t2_wdst",      32'(regwritedst), 32'd3);
    chk("t2_wdata",     32'(writedata),   32'h0000abcd);
    tick();
    chk("t2_empty",     32'(empty),       32'd1);
    chk("t2_rw_empty",  32'(regwrite),    32'd0);
    regread = 1'b1;

    // Fill to full, overflow push ignored, drain in order.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_dst = 4'(i); in_data = 16'(i);
      tick();
    end
    chk("t3_full",      32'(full),        32'd1);
    chk("t3_in_ready",  32'(in_ready),    32'd0);
    chk("t3_count",     32'(count),       32'd4);
    in_dst = 4'd9; in_data = 16'h0005;
    tick();
    in_valid = 1'b0;
    chk("t3_ovf_count", 32'(count),       32'd4);
    regread = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t3_drain_rw",   32'(regwrite),    32'd1);
      chk("t3_drain_dst",  32'(regwritedst), 32'(i));
      chk("t3_drain_data", 32'(writedata),   32'(i));
      tick();
    end
    chk("t3_empty",     32'(empty),       32'd1);
    regread = 1'b1;

    // Duplicate destinations: forward youngest until fully drained.
    in_valid = 1'b1; in_dst = 4'd5; in_data = 16'h1111;
    tick();
    in_data = 16'h2222;
    tick();
    in_valid = 1'b0;
    readregsrc2 = 4'd5;
    #1;
    chk("t4_hazard",    32'(hazard),      32'd2);
    chk("t4_fwd_b",     32'(fwd_b),       32'h00002222);
    chk("t4_fwd_a",     32'(fwd_a),       32'd0);
    regread = 1'b0;
    tick();
    regread = 1'b1;
    #1;
    chk("t4_pop1_count",  32'(count),     32'd1);
    chk("t4_pop1_hazard", 32'(hazard),    32'd2);
    chk("t4_pop1_fwd_b",  32'(fwd_b),     32'h00002222);
    regread = 1'b0;
    tick();
    regread = 1'b1;
    #1;
    chk("t4_pop2_hazard", 32'(hazard),    32'd0);
    chk("t4_pop2_fwd_b",  32'(fwd_b),     32'd0);
    chk("t4_pop2_empty",  32'(empty),     32'd1);
    readregsrc2 = 4'd15;

    // Simultaneous push+pop with pointer wrap.
    in_valid = 1'b1; in_dst = 4'd1;
    for (int k = 0; k < 2; k++) begin
      in_data = 16'h0a00 + 16'(k);
      tick();
    end
    chk("t5_count_pre", 32'(count),       32'd2);
    regread = 1'b0;
    for (int j = 0; j < 10; j++) begin
      in_data = 16'h0a02 + 16'(j);
      #1;
      chk("t5_head_data", 32'(writedata), 32'h00000a00 + 32'(j));
      tick();
      chk("t5_count",     32'(count),     32'd2);
    end
    in_valid = 1'b0;
    #1;
    chk("t5_tail0",     32'(writedata),   32'h00000a0a);
    tick();
    chk("t5_tail1",     32'(writedata),   32'h00000a0b);
    tick();
    chk("t5_empty",     32'(empty),       32'd1);
    regread = 1'b1;

    // All three sources match one pending entry.
    in_valid = 1'b1; in_dst = 4'd7; in_data = 16'h00ff;
    tick();
    in_valid = 1'b0;
    readregsrc1 = 4'd7; readregsrc2 = 4'd7; readregsrc3 = 4'd7;
    #1;
    chk("t6_hazard",    32'(hazard),      32'd7);
    chk("t6_fwd_a",     32'(fwd_a),       32'h000000ff);
    chk("t6_fwd_b",     32'(fwd_b),       32'h000000ff);
    chk("t6_fwd_c",     32'(fwd_c),       32'h000000ff);

    // Reset mid-traffic with three entries discards everything.
    in_valid = 1'b1; in_dst = 4'd2; in_data = 16'h0202;
    tick();
    in_dst = 4'd3; in_data = 16'h0303;
    tick();
    in_valid = 1'b0;
    chk("t1_count_pre", 32'(count),       32'd3);
    #2;
    rst_n   = 1'b0;
    regread = 1'b0;
    #1;
    chk("t1_empty",     32'(empty),       32'd1);
    chk("t1_count",     32'(count),       32'd0);
    chk("t1_regwrite",  32'(regwrite),    32'd0);
    chk("t1_hazard",    32'(hazard),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t1_post_rw",   32'(regwrite),    32'd0);
    chk("t1_post_empty", 32'(empty),      32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
